// File: rtl/main_sysctl_if.sv
// Bus bundle between the board/CPU side and main_sysctl: latch, interrupt,
// sound-handshake and watchdog strobes plus the registered outputs.
interface main_sysctl_if #(
  parameter int LATW = 8,
  parameter int NIRQ = 1
);
  localparam int AW = (LATW > 1) ? $clog2(LATW) : 1;

  logic            CE;
  logic            LATWR;
  logic [AW-1:0]   LATAD;
  logic            LATD;
  logic [LATW-1:0] LAT;
  logic [NIRQ-1:0] TRIG;
  logic [NIRQ-1:0] IACK;
  logic [NIRQ-1:0] IRQ;
  logic            SRQWR;
  logic            SNOWR;
  logic [7:0]      CPUD;
  logic [7:0]      SNDNO;
  logic            SNDRQ;
  logic            SNDACK;
  logic            WDTKICK;
  logic            WDTRST;

  modport master (
    output CE, LATWR, LATAD, LATD, TRIG, IACK, SRQWR, SNOWR, CPUD, SNDACK, WDTKICK,
    input  LAT, IRQ, SNDNO, SNDRQ, WDTRST
  );

  modport slave (
    input  CE, LATWR, LATAD, LATD, TRIG, IACK, SRQWR, SNOWR, CPUD, SNDACK, WDTKICK,
    output LAT, IRQ, SNDNO, SNDRQ, WDTRST
  );
endinterface

// File: rtl/main_sysctl.sv
// Main-CPU system control: addressable output latch, maskable edge-triggered
// interrupts, sound request/number handshake and watchdog reset generator.
module main_sysctl #(
  parameter int          LATW   = 8,
  parameter int          NIRQ   = 1,
  parameter int          SRQLEN = 2,
  parameter int          WDTW   = 16,
  parameter int unsigned WDTLIM = 32'd65535,
  parameter int          RSTLEN = 16,
  parameter bit          WDTEN  = 1'b1
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  main_sysctl_if.slave  bus
);
  localparam int AW  = (LATW > 1) ? $clog2(LATW) : 1;
  localparam int SCW = $clog2(SRQLEN + 1);
  localparam int PCW = $clog2(RSTLEN + 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_FIRE = 1'b1;

  localparam logic [WDTW-1:0] WDT_LIM  = WDTW'(WDTLIM);
  localparam logic [SCW-1:0]  SRQ_LOAD = SCW'(SRQLEN);
  localparam logic [PCW-1:0]  RST_LOAD = PCW'(RSTLEN);

  logic [LATW-1:0] r_lat,   w_lat;
  logic [NIRQ-1:0] r_tprev, w_tprev;
  logic [NIRQ-1:0] r_pend,  w_pend;
  logic [NIRQ-1:0] r_irq,   w_irq;
  logic [NIRQ-1:0] w_rise,  w_mfall;
  logic [7:0]      r_sndno, w_sndno;
  logic [SCW-1:0]  r_scnt,  w_scnt;
  logic            r_sndrq, w_sndrq;
  logic [WDTW-1:0] r_wcnt,  w_wcnt;
  logic [PCW-1:0]  r_pcnt,  w_pcnt;
  logic [0:0]      r_state, w_state;
  logic            r_wdtrst, w_wdtrst;

  // Latch write and per-channel pending/IRQ next state.
  always_comb begin
    w_lat = r_lat;
    for (int i = 0; i < LATW; i++) begin
      if (bus.CE && bus.LATWR && (bus.LATAD == AW'(i))) begin
        w_lat[i] = bus.LATD;
      end else begin
        w_lat[i] = r_lat[i];
      end
    end

    w_tprev = bus.CE ? bus.TRIG : r_tprev;
    w_rise  = bus.TRIG & ~r_tprev;
    // w_lat equals r_lat outside CE cycles, so a mask fall is CE-qualified here.
    w_mfall = r_lat[NIRQ-1:0] & ~w_lat[NIRQ-1:0];

    w_pend = r_pend;
    for (int i = 0; i < NIRQ; i++) begin
      if (!bus.CE) begin
        w_pend[i] = r_pend[i];
      end else if (w_mfall[i]) begin
        w_pend[i] = 1'b0;
      end else if (bus.IACK[i]) begin
        w_pend[i] = 1'b0;
      end else if (w_rise[i]) begin
        w_pend[i] = 1'b1;
      end else begin
        w_pend[i] = r_pend[i];
      end
    end
    w_irq = w_pend & w_lat[NIRQ-1:0];
  end

  // Sound number register and request pulse counter.
  always_comb begin
    w_sndno = (bus.CE && bus.SNOWR) ? bus.CPUD : r_sndno;
    w_scnt  = r_scnt;
    if (!bus.CE) begin
      w_scnt = r_scnt;
    end else if (bus.SRQWR) begin
      w_scnt = SRQ_LOAD;
    end else if (r_scnt != {SCW{1'b0}}) begin
      w_scnt = bus.SNDACK ? {SCW{1'b0}} : (r_scnt - SCW'(1));
    end else begin
      w_scnt = r_scnt;
    end
    w_sndrq = (w_scnt != {SCW{1'b0}});
  end

  // Watchdog RUN/FIRE sequencing; the counter never counts past WDTLIM.
  always_comb begin
    w_wcnt   = r_wcnt;
    w_pcnt   = r_pcnt;
    w_state  = r_state;
    w_wdtrst = r_wdtrst;
    if (!WDTEN) begin
      w_wcnt   = {WDTW{1'b0}};
      w_pcnt   = {PCW{1'b0}};
      w_state  = ST_RUN;
      w_wdtrst = 1'b0;
    end else if (!bus.CE) begin
      w_state = r_state;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_wcnt >= WDT_LIM) begin
            w_state  = ST_FIRE;
            w_wdtrst = 1'b1;
            w_pcnt   = RST_LOAD;
            w_wcnt   = {WDTW{1'b0}};
          end else if (bus.WDTKICK) begin
            w_wcnt = {WDTW{1'b0}};
          end else begin
            w_wcnt = r_wcnt + WDTW'(1);
          end
        end
        ST_FIRE: begin
          w_wcnt = {WDTW{1'b0}};
          if (r_pcnt <= PCW'(1)) begin
            w_state  = ST_RUN;
            w_wdtrst = 1'b0;
            w_pcnt   = {PCW{1'b0}};
          end else begin
            w_wdtrst = 1'b1;
            w_pcnt   = r_pcnt - PCW'(1);
          end
        end
        default: begin
          w_state  = ST_RUN;
          w_wdtrst = 1'b0;
          w_wcnt   = {WDTW{1'b0}};
          w_pcnt   = {PCW{1'b0}};
        end
      endcase
    end
  end

  // State registers; all outputs come straight from here.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lat    <= {LATW{1'b0}};
      r_tprev  <= {NIRQ{1'b0}};
      r_pend   <= {NIRQ{1'b0}};
      r_irq    <= {NIRQ{1'b0}};
      r_sndno  <= 8'h00;
      r_scnt   <= {SCW{1'b0}};
      r_sndrq  <= 1'b0;
      r_wcnt   <= {WDTW{1'b0}};
      r_pcnt   <= {PCW{1'b0}};
      r_state  <= ST_RUN;
      r_wdtrst <= 1'b0;
    end else begin
      r_lat    <= w_lat;
      r_tprev  <= w_tprev;
      r_pend   <= w_pend;
      r_irq    <= w_irq;
      r_sndno  <= w_sndno;
      r_scnt   <= w_scnt;
      r_sndrq  <= w_sndrq;
      r_wcnt   <= w_wcnt;
      r_pcnt   <= w_pcnt;
      r_state  <= w_state;
      r_wdtrst <= w_wdtrst;
    end
  end

  assign bus.LAT    = r_lat;
  assign bus.IRQ    = r_irq;
  assign bus.SNDNO  = r_sndno;
  assign bus.SNDRQ  = r_sndrq;
  assign bus.WDTRST = r_wdtrst;
endmodule

// File: tb/tb_main_sysctl.sv
// Directed self-checking bench for main_sysctl (LATW=8, NIRQ=2, SRQLEN=2,
// WDTLIM=10, RSTLEN=3).
module tb_main_sysctl;
  logic MCLK;
  logic RESET_N;
  int   n_checks;
  int   n_errors;

  main_sysctl_if #(.LATW(8), .NIRQ(2)) bus ();

  main_sysctl #(
    .LATW(8), .NIRQ(2), .SRQLEN(2), .WDTW(16),
    .WDTLIM(32'd10), .RSTLEN(3), .WDTEN(1'b1)
  ) u_dut (
    .MCLK(MCLK),
    .RESET_N(RESET_N),
    .bus(bus.slave)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic latwr(input logic [2:0] ad, input logic d);
    bus.LATWR = 1'b1;
    bus.LATAD = ad;
    bus.LATD  = d;
    tick();
    bus.LATWR = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_lat"},   32'(bus.LAT),    32'h0);
    check({tag, "_irq"},   32'(bus.IRQ),    32'h0);
    check({tag, "_sndno"}, 32'(bus.SNDNO),  32'h0);
    check({tag, "_sndrq"}, 32'(bus.SNDRQ),  32'h0);
    check({tag, "_wdt"},   32'(bus.WDTRST), 32'h0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    RESET_N     = 1'b0;
    bus.CE      = 1'b1;
    bus.LATWR   = 1'b0;
    bus.LATAD   = 3'd0;
    bus.LATD    = 1'b0;
    bus.TRIG    = 2'b00;
    bus.IACK    = 2'b00;
    bus.SRQWR   = 1'b0;
    bus.SNOWR   = 1'b0;
    bus.CPUD    = 8'h00;
    bus.SNDACK  = 1'b0;
    bus.WDTKICK = 1'b0;

    #12;
    check_idle_outputs("reset");
    RESET_N = 1'b1;

    // Watchdog free-running: fires on CE cycles 11..13, again 25..27.
    for (int k = 1; k <= 28; k++) begin
      tick();
      check($sformatf("wdt_free_c%0d", k), 32'(bus.WDTRST),
            32'(((k >= 11) && (k <= 13)) || ((k >= 25) && (k <= 27))));
    end

    // Kicks every 5 CE cycles keep the watchdog quiet.
    for (int k = 0; k < 40; k++) begin
      bus.WDTKICK = ((k % 5) == 0);
      tick();
      check($sformatf("wdt_kick_c%0d", k), 32'(bus.WDTRST), 32'h0);
    end
    bus.WDTKICK = 1'b1;

    latwr(3'd5, 1'b1);
    latwr(3'd0, 1'b1);
    check("lat_21", 32'(bus.LAT), 32'h21);
    latwr(3'd5, 1'b0);
    check("lat_01", 32'(bus.LAT), 32'h01);

    latwr(3'd1, 1'b1);
    check("lat_03", 32'(bus.LAT), 32'h03);
    bus.TRIG = 2'b01;
    tick();
    check("irq_edge", 32'(bus.IRQ), 32'h1);
    tick();
    check("irq_hold", 32'(bus.IRQ), 32'h1);
    bus.IACK = 2'b01;
    tick();
    bus.IACK = 2'b00;
    check("irq_ack", 32'(bus.IRQ), 32'h0);
    bus.TRIG = 2'b00;
    tick();

    latwr(3'd0, 1'b0);
    bus.TRIG = 2'b01;
    tick();
    check("irq_masked", 32'(bus.IRQ), 32'h0);
    bus.TRIG = 2'b00;
    latwr(3'd0, 1'b1);
    check("irq_unmask", 32'(bus.IRQ), 32'h1);
    bus.IACK = 2'b01;
    tick();
    bus.IACK = 2'b00;
    check("irq_ack2", 32'(bus.IRQ), 32'h0);

    bus.TRIG = 2'b01;
    tick();
    check("irq_edge2", 32'(bus.IRQ), 32'h1);
    bus.TRIG = 2'b00;
    latwr(3'd0, 1'b0);
    check("irq_mfall", 32'(bus.IRQ), 32'h0);
    latwr(3'd0, 1'b1);
    check("irq_remask", 32'(bus.IRQ), 32'h0);

    bus.TRIG = 2'b10;
    tick();
    check("irq_ch1", 32'(bus.IRQ), 32'h2);
    bus.TRIG = 2'b00;
    bus.IACK = 2'b10;
    tick();
    bus.IACK = 2'b00;
    check("irq_ch1_ack", 32'(bus.IRQ), 32'h0);
    bus.TRIG = 2'b10;
    bus.IACK = 2'b10;
    tick();
    bus.TRIG = 2'b00;
    bus.IACK = 2'b00;
    check("irq_ack_beats_edge", 32'(bus.IRQ), 32'h0);
    tick();

    bus.CPUD  = 8'h3C;
    bus.SNOWR = 1'b1;
    bus.SRQWR = 1'b1;
    tick();
    bus.SNOWR = 1'b0;
    bus.SRQWR = 1'b0;
    check("sndno", 32'(bus.SNDNO), 32'h3C);
    check("srq_c1", 32'(bus.SNDRQ), 32'h1);
    tick();
    check("srq_c2", 32'(bus.SNDRQ), 32'h1);
    tick();
    check("srq_c3", 32'(bus.SNDRQ), 32'h0);

    bus.SRQWR = 1'b1;
    tick();
    bus.SRQWR = 1'b0;
    check("srqx_c1", 32'(bus.SNDRQ), 32'h1);
    bus.SRQWR = 1'b1;
    tick();
    bus.SRQWR = 1'b0;
    check("srqx_c2", 32'(bus.SNDRQ), 32'h1);
    tick();
    check("srqx_c3", 32'(bus.SNDRQ), 32'h1);
    tick();
    check("srqx_c4", 32'(bus.SNDRQ), 32'h0);

    bus.SRQWR = 1'b1;
    tick();
    bus.SRQWR = 1'b0;
    check("srqa_c1", 32'(bus.SNDRQ), 32'h1);
    bus.SNDACK = 1'b1;
    tick();
    bus.SNDACK = 1'b0;
    check("srqa_ack", 32'(bus.SNDRQ), 32'h0);

    bus.SRQWR  = 1'b1;
    bus.SNDACK = 1'b1;
    tick();
    bus.SRQWR  = 1'b0;
    bus.SNDACK = 1'b0;
    check("srq_wins_c1", 32'(bus.SNDRQ), 32'h1);
    tick();
    check("srq_wins_c2", 32'(bus.SNDRQ), 32'h1);
    tick();
    check("srq_wins_c3", 32'(bus.SNDRQ), 32'h0);

    // CE low with every strobe asserted: nothing may move.
    bus.CE      = 1'b0;
    bus.LATWR   = 1'b1;
    bus.LATAD   = 3'd2;
    bus.LATD    = 1'b1;
    bus.TRIG    = 2'b11;
    bus.IACK    = 2'b11;
    bus.SRQWR   = 1'b1;
    bus.SNOWR   = 1'b1;
    bus.CPUD    = 8'hA5;
    bus.SNDACK  = 1'b1;
    bus.WDTKICK = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("ce_lat",   32'(bus.LAT),    32'h03);
    check("ce_irq",   32'(bus.IRQ),    32'h0);
    check("ce_sndno", 32'(bus.SNDNO),  32'h3C);
    check("ce_sndrq", 32'(bus.SNDRQ),  32'h0);
    check("ce_wdt",   32'(bus.WDTRST), 32'h0);
    bus.LATWR  = 1'b0;
    bus.TRIG   = 2'b00;
    bus.IACK   = 2'b00;
    bus.SRQWR  = 1'b0;
    bus.SNOWR  = 1'b0;
    bus.SNDACK = 1'b0;
    bus.CE     = 1'b1;
    tick();
    bus.WDTKICK = 1'b0;

    // Bring up WDTRST and SNDRQ together, then reset asynchronously.
    for (int k = 1; k <= 11; k++) tick();
    check("ar_wdt_up", 32'(bus.WDTRST), 32'h1);
    bus.SRQWR = 1'b1;
    tick();
    bus.SRQWR = 1'b0;
    check("ar_srq_up", 32'(bus.SNDRQ), 32'h1);
    check("ar_wdt_still", 32'(bus.WDTRST), 32'h1);
    #2;
    RESET_N = 1'b0;
    #1;
    check_idle_outputs("async");
    #1;
    RESET_N = 1'b1;
    tick();
    check_idle_outputs("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
